// File: rtl/parking_pkg.sv
// Shared types and constants for the parking-lot sensor stimulus driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package parking_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P1   = 3'd1,
        ST_P2   = 3'd2,
        ST_P3   = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    localparam logic DIR_ENTRY = 1'b1;
    localparam logic DIR_EXIT  = 1'b0;

    // Blocked view of the two sensors: 1 means a vehicle covers the beam.
    typedef struct packed {
        logic a_blk;
        logic b_blk;
    } blk_t;

    // Entry crosses A (outer) first, exit crosses B (inner) first.
    // GAP is the vehicle clear of both beams before returning to IDLE.
    localparam blk_t ENTRY_P1  = 2'b10;
    localparam blk_t ENTRY_P2  = 2'b11;
    localparam blk_t ENTRY_P3  = 2'b01;
    localparam blk_t ENTRY_GAP = 2'b00;
    localparam blk_t EXIT_P1   = 2'b01;
    localparam blk_t EXIT_P2   = 2'b11;
    localparam blk_t EXIT_P3   = 2'b10;
    localparam blk_t EXIT_GAP  = 2'b00;

    localparam logic [2:0] OCC_MAX = 3'd7;

    // Blocked pattern to present while in a given state for a given direction.
    function automatic blk_t phase_blk(input state_t st, input logic dir);
        blk_t b;
        b = 2'b00;
        case (st)
            ST_P1:   b = (dir == DIR_ENTRY) ? ENTRY_P1  : EXIT_P1;
            ST_P2:   b = (dir == DIR_ENTRY) ? ENTRY_P2  : EXIT_P2;
            ST_P3:   b = (dir == DIR_ENTRY) ? ENTRY_P3  : EXIT_P3;
            ST_GAP:  b = (dir == DIR_ENTRY) ? ENTRY_GAP : EXIT_GAP;
            default: b = 2'b00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Phase dwell timer: load a count, decrement while running, flag the last cycle.
// Latency: expire is combinational from the count; a load of N gives expire N cycles later.
// Backpressure: none; load takes priority over counting.
module dwell_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             run,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    // Count down toward zero while running; a load restarts the dwell.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire = run && (cnt == '0);

endmodule

// File: rtl/car_sensor_driver.sv
// Drives active-low A/B car sensors through one entry/exit passage and tracks occupancy.
// Latency: 4*DWELL_CYCLES busy cycles per passage; done one cycle after the last GAP cycle.
// Backpressure: start is only taken while ready=1; starts while busy are dropped.
module car_sensor_driver
    import parking_pkg::*;
#(
    parameter int DWELL_CYCLES = 16,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       dir,
    output logic       ready,
    output logic       sensor_a,
    output logic       sensor_b,
    output logic       done,
    output logic [2:0] exp_count
);

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic       dir_q;
    logic       dir_nxt;
    logic       tmr_load;
    logic       tmr_run;
    logic       tmr_expire;
    blk_t       blk_nxt;
    logic       ready_nxt;
    logic       done_nxt;
    logic [2:0] count_nxt;

    dwell_timer #(
        .CNT_W(CNT_W)
    ) u_dwell_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .run     (tmr_run),
        .load_val(DWELL_LOAD),
        .expire  (tmr_expire)
    );

    // State and latched direction register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            dir_q <= DIR_EXIT;
        end else begin
            state <= state_nxt;
            dir_q <= dir_nxt;
        end
    end

    // Phase sequencing and next values for the registered outputs.
    always_comb begin
        state_nxt = state;
        dir_nxt   = dir_q;
        tmr_load  = 1'b0;
        tmr_run   = (state != ST_IDLE);
        done_nxt  = 1'b0;
        count_nxt = exp_count;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_P1;
                    dir_nxt   = dir;
                    tmr_load  = 1'b1;
                end
            end
            ST_P1: begin
                if (tmr_expire) begin
                    state_nxt = ST_P2;
                    tmr_load  = 1'b1;
                end
            end
            ST_P2: begin
                if (tmr_expire) begin
                    state_nxt = ST_P3;
                    tmr_load  = 1'b1;
                end
            end
            ST_P3: begin
                if (tmr_expire) begin
                    state_nxt = ST_GAP;
                    tmr_load  = 1'b1;
                end
            end
            ST_GAP: begin
                if (tmr_expire) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                    if (dir_q == DIR_ENTRY) begin
                        if (exp_count != OCC_MAX) count_nxt = exp_count + 3'd1;
                    end else begin
                        if (exp_count != 3'd0) count_nxt = exp_count - 3'd1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        blk_nxt   = phase_blk(state_nxt, dir_nxt);
        ready_nxt = (state_nxt == ST_IDLE);
    end

    // Outputs are registered from the next-state view so they line up with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            sensor_a  <= 1'b1;
            sensor_b  <= 1'b1;
            ready     <= 1'b1;
            done      <= 1'b0;
            exp_count <= 3'd0;
        end else begin
            sensor_a  <= ~blk_nxt.a_blk;
            sensor_b  <= ~blk_nxt.b_blk;
            ready     <= ready_nxt;
            done      <= done_nxt;
            exp_count <= count_nxt;
        end
    end

endmodule
